// File: rtl/bus_fill_ctrl.sv
// bus_fill_ctrl: host-sequenced lane pattern generator (fill / walking-one / clear)
// with start/done handshake and programmable step rate.
`default_nettype none

module bus_fill_ctrl #(
  parameter int WIDTH = 10,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_abort,
  output logic [WIDTH-1:0] o_bus_out,
  output logic [3:0]       o_idx,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  localparam logic [1:0] C_MODE_FILL  = 2'b00;
  localparam logic [1:0] C_MODE_WALK  = 2'b01;
  localparam logic [1:0] C_MODE_CLEAR = 2'b10;
  localparam logic [1:0] C_MODE_ILL   = 2'b11;
  localparam logic [3:0] C_IDX_LAST   = 4'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIN  = 2'b10
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_bus;
  logic [3:0]       r_idx;
  logic [DIV_W-1:0] r_cnt;
  logic [1:0]       r_mode;
  logic [DIV_W-1:0] r_div;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_bus_nxt;
  logic [3:0]       w_idx_nxt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [1:0]       w_mode_nxt;
  logic [DIV_W-1:0] w_div_nxt;
  logic             w_done_nxt;
  logic             w_err_nxt;
  logic [WIDTH-1:0] w_onehot;

  assign w_onehot = {{(WIDTH-1){1'b0}}, 1'b1} << r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_bus   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_mode  <= C_MODE_FILL;
      r_div   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bus   <= w_bus_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mode  <= w_mode_nxt;
      r_div   <= w_div_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bus_nxt   = r_bus;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode;
    w_div_nxt   = r_div;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // ABORT masks START entirely, including the illegal-mode error.
        if (i_start && !i_abort) begin
          if (i_mode == C_MODE_ILL) begin
            w_err_nxt = 1'b1;
          end else begin
            w_state_nxt = S_RUN;
            w_mode_nxt  = i_mode;
            w_div_nxt   = i_div;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
            w_bus_nxt   = (i_mode == C_MODE_CLEAR) ? {WIDTH{1'b1}} : '0;
          end
        end
      end

      S_RUN: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
          w_bus_nxt   = '0;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end else if (r_cnt == r_div) begin
          w_cnt_nxt = '0;
          unique case (r_mode)
            C_MODE_FILL:  w_bus_nxt = r_bus | w_onehot;
            C_MODE_WALK:  w_bus_nxt = w_onehot;
            C_MODE_CLEAR: w_bus_nxt = r_bus & ~w_onehot;
            default:      w_bus_nxt = r_bus;
          endcase
          // DONE is registered on FIN entry so it is high exactly during FIN.
          if (r_idx == C_IDX_LAST) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_FIN;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 4'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + DIV_W'(1);
        end
      end

      S_FIN: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_bus_out = r_bus;
  assign o_idx     = r_idx;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_err     = r_err;

endmodule

`default_nettype wire
